img_conv_sequencer: RTL and testbench

//  Opcode-driven command sequencer for the image-convolution SoC.
//  - Decodes host ops; holds the dimension, sigma and iteration registers.
//  - Launches the RX/TX/row-conv sub-controllers and drives the SRAM-mux select.
//  - Runs K blur iterations, each of 2 transposing passes, using a checked start/ack/done handshake.

---
 rtl/img_conv_pkg.sv | 43 ++++
 rtl/img_conv_seq_launch.sv | 65 ++++++
 rtl/img_conv_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_img_conv_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/img_conv_pkg.sv
// rtl/img_conv_pkg.sv - opcodes, sequencer states, SRAM-mux selects and status bit indices
package img_conv_pkg;

    typedef enum logic [3:0] {
        OP_NOP        = 4'h0,
        OP_SET_NROWS  = 4'h1,
        OP_SET_NCOLS  = 4'h2,
        OP_SET_SIGMA  = 4'h3,
        OP_SET_ITERS  = 4'h4,
        OP_GET_NROWS  = 4'h5,
        OP_GET_NCOLS  = 4'h6,
        OP_GET_SIGMA  = 4'h7,
        OP_GET_ITERS  = 4'h8,
        OP_GET_STATUS = 4'h9,
        OP_CLR_STATUS = 4'hA,
        OP_IMG_RX     = 4'hB,
        OP_IMG_TX     = 4'hC,
        OP_CONV       = 4'hD,
        OP_GET_CYC_LO = 4'hE,
        OP_GET_CYC_HI = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_RUN      = 3'd3,
        S_DONE     = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_RX   = 2'd1,
        SEL_TX   = 2'd2,
        SEL_CONV = 2'd3
    } sram_sel_t;

    localparam int ST_CLAMP    = 0;
    localparam int ST_TIMEOUT  = 1;
    localparam int ST_ERR_BUSY = 2;
    localparam int ST_W        = 3;

endpackage

// File: rtl/img_conv_seq_launch.sv
// rtl/img_conv_seq_launch.sv - start pulse generation, ack timeout counter and busy-fall detection
module img_conv_seq_launch
    import img_conv_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      launch,
    input  logic      waiting,
    input  logic      running,
    input  sram_sel_t sel,
    input  logic      rx_busy,
    input  logic      tx_busy,
    input  logic      conv_busy,
    output logic      rx_start,
    output logic      tx_start,
    output logic      conv_start,
    output logic      ack,
    output logic      fin,
    output logic      timeout
);

    localparam int              CNT_W   = $clog2(ACK_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(ACK_TIMEOUT + 1);

    logic             sub_busy;
    logic             busy_q;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        sub_busy = 1'b0;
        case (sel)
            SEL_RX:   sub_busy = rx_busy;
            SEL_TX:   sub_busy = tx_busy;
            SEL_CONV: sub_busy = conv_busy;
            default:  sub_busy = 1'b0;
        endcase
    end

    // cnt is zero in the start-pulse cycle and saturates at the limit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_start   <= 1'b0;
            tx_start   <= 1'b0;
            conv_start <= 1'b0;
            busy_q     <= 1'b0;
            cnt        <= '0;
        end else begin
            rx_start   <= launch && (sel == SEL_RX);
            tx_start   <= launch && (sel == SEL_TX);
            conv_start <= launch && (sel == SEL_CONV);
            busy_q     <= sub_busy;
            if (!waiting)
                cnt <= '0;
            else if (cnt != CNT_LIM)
                cnt <= cnt + 1'b1;
        end
    end

    assign ack     = waiting & sub_busy;
    assign timeout = waiting & ~sub_busy & (cnt == CNT_LIM);
    assign fin     = running & busy_q & ~sub_busy;

endmodule

// File: rtl/img_conv_sequencer.sv
// rtl/img_conv_sequencer.sv - opcode-driven convolution sequencer; IMG_CONV_SEQ_PERF_EN adds a cycle counter
module img_conv_sequencer
    import img_conv_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DIM_W       = 8,
    parameter int MAX_ROWS    = 64,
    parameter int MAX_COLS    = 64,
    parameter int ITER_W      = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  opcode_t           op,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done,
    output logic              rx_start,
    output logic              tx_start,
    output logic              conv_start,
    input  logic              rx_busy,
    input  logic              tx_busy,
    input  logic              conv_busy,
    output logic              conv_swap,
    output logic [DIM_W-1:0]  conv_nrows,
    output logic [DIM_W-1:0]  conv_ncols,
    output logic [DIM_W-1:0]  nrows,
    output logic [DIM_W-1:0]  ncols,
    output logic [2:0]        sigma,
    output sram_sel_t         sram_sel
);

    seq_state_t        state;
    logic [ITER_W-1:0] iters;
    logic [ITER_W:0]   pass;
    logic [ITER_W:0]   last_pass;
    logic [ST_W-1:0]   status;
    logic              ack, fin, timeout;
`ifdef IMG_CONV_SEQ_PERF_EN
    logic [15:0]       cyc;
    logic              cyc_on;
`endif

    function automatic logic [DIM_W-1:0] clamp_dim(input logic [DATA_W-1:0] v, input int lim);
        if (v == '0)
            return DIM_W'(1);
        else if (v > DATA_W'(lim))
            return DIM_W'(lim);
        else
            return v[DIM_W-1:0];
    endfunction

    // Two transposing passes per iteration; the final pass index is odd
    assign last_pass  = {iters, 1'b0} - {{ITER_W{1'b0}}, 1'b1};
    assign busy       = (state != S_IDLE);
    assign conv_nrows = conv_swap ? ncols : nrows;
    assign conv_ncols = conv_swap ? nrows : ncols;

    img_conv_seq_launch #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_launch (
        .clk        (clk),
        .rstn       (rstn),
        .launch     (state == S_LAUNCH),
        .waiting    (state == S_WAIT_ACK),
        .running    (state == S_RUN),
        .sel        (sram_sel),
        .rx_busy    (rx_busy),
        .tx_busy    (tx_busy),
        .conv_busy  (conv_busy),
        .rx_start   (rx_start),
        .tx_start   (tx_start),
        .conv_start (conv_start),
        .ack        (ack),
        .fin        (fin),
        .timeout    (timeout)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            nrows     <= DIM_W'(8);
            ncols     <= DIM_W'(8);
            sigma     <= 3'd0;
            iters     <= ITER_W'(1);
            pass      <= '0;
            status    <= '0;
            dout      <= '0;
            done      <= 1'b0;
            conv_swap <= 1'b0;
            sram_sel  <= SEL_HOLD;
`ifdef IMG_CONV_SEQ_PERF_EN
            cyc       <= '0;
            cyc_on    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (en && state != S_IDLE)
                status[ST_ERR_BUSY] <= 1'b1;
`ifdef IMG_CONV_SEQ_PERF_EN
            if (cyc_on && cyc != 16'hFFFF)
                cyc <= cyc + 1'b1;
`endif
            case (state)
                S_IDLE: if (en) begin
                    case (op)
                        OP_SET_NROWS: begin
                            nrows <= clamp_dim(din, MAX_ROWS);
                            dout  <= DATA_W'(clamp_dim(din, MAX_ROWS));
                            if (din > DATA_W'(MAX_ROWS))
                                status[ST_CLAMP] <= 1'b1;
                        end
                        OP_SET_NCOLS: begin
                            ncols <= clamp_dim(din, MAX_COLS);
                            dout  <= DATA_W'(clamp_dim(din, MAX_COLS));
                            if (din > DATA_W'(MAX_COLS))
                                status[ST_CLAMP] <= 1'b1;
                        end
                        OP_SET_SIGMA:  sigma <= din[2:0];
                        OP_SET_ITERS:  iters <= (din[ITER_W-1:0] == '0) ? ITER_W'(1) : din[ITER_W-1:0];
                        OP_GET_NROWS:  dout <= DATA_W'(nrows);
                        OP_GET_NCOLS:  dout <= DATA_W'(ncols);
                        OP_GET_SIGMA:  dout <= DATA_W'(sigma);
                        OP_GET_ITERS:  dout <= DATA_W'(iters);
                        OP_GET_STATUS: dout <= DATA_W'(status);
                        OP_CLR_STATUS: status <= '0;
`ifdef IMG_CONV_SEQ_PERF_EN
                        OP_GET_CYC_LO: dout <= DATA_W'(cyc[7:0]);
                        OP_GET_CYC_HI: dout <= DATA_W'(cyc[15:8]);
`else
                        OP_GET_CYC_LO: dout <= '0;
                        OP_GET_CYC_HI: dout <= '0;
`endif
                        OP_IMG_RX, OP_IMG_TX, OP_CONV: begin
                            if (op == OP_IMG_RX)
                                sram_sel <= SEL_RX;
                            else if (op == OP_IMG_TX)
                                sram_sel <= SEL_TX;
                            else
                                sram_sel <= SEL_CONV;
                            pass      <= '0;
                            conv_swap <= 1'b0;
                            state     <= S_LAUNCH;
`ifdef IMG_CONV_SEQ_PERF_EN
                            cyc       <= '0;
                            cyc_on    <= 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
                S_LAUNCH: state <= S_WAIT_ACK;
                S_WAIT_ACK: begin
                    if (ack) begin
                        state <= S_RUN;
                    end else if (timeout) begin
                        status[ST_TIMEOUT] <= 1'b1;
                        done      <= 1'b1;
                        conv_swap <= 1'b0;
                        sram_sel  <= SEL_HOLD;
                        state     <= S_IDLE;
`ifdef IMG_CONV_SEQ_PERF_EN
                        cyc_on    <= 1'b0;
`endif
                    end
                end
                S_RUN: if (fin) state <= S_DONE;
                S_DONE: begin
                    if (sram_sel == SEL_CONV && pass < last_pass) begin
                        pass      <= pass + 1'b1;
                        conv_swap <= ~pass[0];
                        state     <= S_LAUNCH;
                    end else begin
                        if (sram_sel == SEL_CONV)
                            dout <= DATA_W'(1);
                        done      <= 1'b1;
                        conv_swap <= 1'b0;
                        sram_sel  <= SEL_HOLD;
                        state     <= S_IDLE;
`ifdef IMG_CONV_SEQ_PERF_EN
                        cyc_on    <= 1'b0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_conv_sequencer.sv
// tb/tb_img_conv_sequencer.sv - directed self-checking bench for img_conv_sequencer
module tb_img_conv_sequencer;
    import img_conv_pkg::*;

    localparam int ACK_TO = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    opcode_t    op = OP_NOP;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       busy, done;
    logic       rx_start, tx_start, conv_start;
    logic       rx_busy = 1'b0, tx_busy = 1'b0, conv_busy = 1'b0;
    logic       conv_swap;
    logic [7:0] conv_nrows, conv_ncols, nrows, ncols;
    logic [2:0] sigma;
    sram_sel_t  sram_sel;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_rx_start = 0, n_tx_start = 0, n_conv_start = 0, n_done = 0;
    int unsigned tick = 0;
    logic        swap_log[$];
    logic [7:0]  rows_log[$];
    logic [7:0]  sb_q[$];
    int          exp_swap[4] = '{0, 1, 0, 1};
    int          exp_rows[4] = '{4, 6, 4, 6};

    img_conv_sequencer #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .op         (op),
        .din        (din),
        .dout       (dout),
        .busy       (busy),
        .done       (done),
        .rx_start   (rx_start),
        .tx_start   (tx_start),
        .conv_start (conv_start),
        .rx_busy    (rx_busy),
        .tx_busy    (tx_busy),
        .conv_busy  (conv_busy),
        .conv_swap  (conv_swap),
        .conv_nrows (conv_nrows),
        .conv_ncols (conv_ncols),
        .nrows      (nrows),
        .ncols      (ncols),
        .sigma      (sigma),
        .sram_sel   (sram_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    always @(negedge clk) begin
        if (rx_start)   n_rx_start++;
        if (tx_start)   n_tx_start++;
        if (done)       n_done++;
        if (conv_start) begin
            n_conv_start++;
            swap_log.push_back(conv_swap);
            rows_log.push_back(conv_nrows);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host(input opcode_t o, input logic [7:0] d);
        @(negedge clk);
        en  = 1'b1;
        op  = o;
        din = d;
        @(negedge clk);
        en  = 1'b0;
        op  = OP_NOP;
    endtask

    task automatic expect_dout(input string tag);
        logic [7:0] e;
        e = sb_q.pop_front();
        chk(tag, dout, e);
    endtask

    function automatic logic start_of(input int w);
        case (w)
            0:       return rx_start;
            1:       return tx_start;
            default: return conv_start;
        endcase
    endfunction

    task automatic wait_start(input int which, input string tag);
        int k = 0;
        while (!start_of(which) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_start_seen"}, start_of(which), 1);
    endtask

    task automatic wait_done(input string tag, output int k);
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, done, 1);
    endtask

    initial begin
        int k, base, bad;
        int unsigned t0, n_cyc;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_starts", {rx_start, tx_start, conv_start}, 0);
        chk("rst_swap", conv_swap, 0);
        chk("rst_sel", 32'(sram_sel), 32'(SEL_HOLD));
        chk("rst_dims", {nrows, ncols}, {8'd8, 8'd8});
        chk("rst_sigma", sigma, 0);
        rstn = 1'b1;
        host(OP_GET_ITERS, 8'd0);  sb_q.push_back(8'd1); expect_dout("rst_iters");
        host(OP_GET_STATUS, 8'd0); sb_q.push_back(8'd0); expect_dout("rst_status");

        // dimension clamping
        host(OP_SET_NROWS, 8'd0);   sb_q.push_back(8'd1);  expect_dout("nrows0_echo");
        host(OP_GET_NROWS, 8'd0);   sb_q.push_back(8'd1);  expect_dout("nrows0_get");
        host(OP_SET_NCOLS, 8'd200); sb_q.push_back(8'd64); expect_dout("ncols200_echo");
        chk("ncols_port", ncols, 64);
        host(OP_GET_STATUS, 8'd0);  sb_q.push_back(8'd1);  expect_dout("clamp_status");
        host(OP_CLR_STATUS, 8'd0);

        // RX transfer
        base = n_done;
        host(OP_IMG_RX, 8'd0);
        chk("rx_sel_launch", 32'(sram_sel), 32'(SEL_RX));
        wait_start(0, "rx");
        repeat (3) @(negedge clk);
        rx_busy = 1'b1;
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (sram_sel != SEL_RX) bad++;
        end
        rx_busy = 1'b0;
        wait_done("rx", k);
        chk("rx_busy_after", busy, 0);
        @(negedge clk);
        chk("rx_sel_held", bad, 0);
        chk("rx_start_count", n_rx_start, 1);
        chk("rx_done_count", n_done - base, 1);
        chk("rx_sel_hold", 32'(sram_sel), 32'(SEL_HOLD));

        // two-iteration convolution
        host(OP_SET_ITERS, 8'd2);
        host(OP_SET_NROWS, 8'd4); sb_q.push_back(8'd4); expect_dout("nrows4_echo");
        host(OP_SET_NCOLS, 8'd6); sb_q.push_back(8'd6); expect_dout("ncols6_echo");
        swap_log.delete();
        rows_log.delete();
        base = n_conv_start;
        host(OP_CONV, 8'd0);
        t0 = tick;
        for (int p = 0; p < 4; p++) begin
            wait_start(2, "conv");
            repeat (2) @(negedge clk);
            conv_busy = 1'b1;
            repeat (4) @(negedge clk);
            conv_busy = 1'b0;
        end
        wait_done("conv", k);
        n_cyc = tick - t0;
        sb_q.push_back(8'd1); expect_dout("conv_dout");
        @(negedge clk);
        chk("conv_start_count", n_conv_start - base, 4);
        chk("conv_log_len", rows_log.size(), 4);
        for (int i = 0; i < 4 && i < rows_log.size(); i++) begin
            chk($sformatf("conv_swap_%0d", i), swap_log[i], exp_swap[i]);
            chk($sformatf("conv_rows_%0d", i), rows_log[i], exp_rows[i]);
        end
        chk("conv_swap_end", conv_swap, 0);
`ifdef IMG_CONV_SEQ_PERF_EN
        host(OP_GET_CYC_LO, 8'd0); sb_q.push_back(n_cyc[7:0]);  expect_dout("cyc_lo");
        host(OP_GET_CYC_HI, 8'd0); sb_q.push_back(n_cyc[15:8]); expect_dout("cyc_hi");
`else
        host(OP_GET_CYC_LO, 8'd0); sb_q.push_back(8'd0); expect_dout("cyc_lo");
        host(OP_GET_CYC_HI, 8'd0); sb_q.push_back(8'd0); expect_dout("cyc_hi");
`endif

        // ack timeout
        host(OP_CONV, 8'd0);
        wait_start(2, "to");
        wait_done("to", k);
        chk("timeout_latency", k, ACK_TO + 2);
        chk("timeout_busy", busy, 0);
        host(OP_GET_STATUS, 8'd0); sb_q.push_back(8'd2); expect_dout("timeout_status");
        host(OP_CLR_STATUS, 8'd0);

        // op while busy
        host(OP_SET_SIGMA, 8'd5);
        chk("sigma5", sigma, 5);
        host(OP_IMG_TX, 8'd0);
        wait_start(1, "tx");
        @(negedge clk);
        tx_busy = 1'b1;
        host(OP_GET_SIGMA, 8'd0); sb_q.push_back(8'd2); expect_dout("busy_dout_kept");
        chk("tx_busy_out", busy, 1);
        tx_busy = 1'b0;
        wait_done("tx", k);
        host(OP_GET_STATUS, 8'd0); sb_q.push_back(8'd4); expect_dout("err_busy_status");
        host(OP_CLR_STATUS, 8'd0);
        host(OP_GET_STATUS, 8'd0); sb_q.push_back(8'd0); expect_dout("cleared_status");

        // reset in the middle of pass 2
        host(OP_CONV, 8'd0);
        wait_start(2, "p1");
        repeat (2) @(negedge clk);
        conv_busy = 1'b1;
        repeat (3) @(negedge clk);
        conv_busy = 1'b0;
        wait_start(2, "p2");
        chk("p2_swap", conv_swap, 1);
        @(negedge clk);
        conv_busy = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_swap", conv_swap, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sel", 32'(sram_sel), 32'(SEL_HOLD));
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_dims", {nrows, ncols}, {8'd8, 8'd8});
        chk("mid_rst_starts", {rx_start, tx_start, conv_start}, 0);
        conv_busy = 1'b0;
        base = n_conv_start;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_start_after_rst", n_conv_start - base, 0);
        chk("idle_after_rst", busy, 0);
        host(OP_GET_ITERS, 8'd0); sb_q.push_back(8'd1); expect_dout("iters_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
